// File: rtl/imem_port_arbiter_if.sv
// Signal bundle between the fetch stage / instruction loader, the
// instruction-memory arbiter and the single-port instruction SRAM.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 9
);
    logic              i_wr_req;
    logic [31:0]       i_wr_addr;
    logic [31:0]       i_wr_data;
    logic              o_wr_valid;
    logic              i_rd_req;
    logic [31:0]       i_rd_addr;
    logic              o_rd_gnt;
    logic              o_rd_valid;
    logic [31:0]       o_rd_data;
    logic              i_flush;
    logic              o_addr_err;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;
    logic              o_busy;

    // Arbiter side
    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
        input  i_flush, i_mem_rdata,
        output o_wr_valid, o_rd_gnt, o_rd_valid, o_rd_data, o_addr_err,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
    );

    // Requester / memory side
    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
        output i_flush, i_mem_rdata,
        input  o_wr_valid, o_rd_gnt, o_rd_valid, o_rd_data, o_addr_err,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction SRAM between the loader (writes) and the
// fetch stage (reads), with bounded write priority and flush of in-flight reads.
module imem_port_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int MAX_WR_BURST = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    imem_port_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_WR_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WR_BURST);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_ISSUE = 2'd2,
        READ_RESP  = 2'd3
    } state_t;

    function automatic logic addr_out_of_range(input logic [31:2] addr);
        return |addr[31:ADDR_W+2];
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [31:2] addr);
        return addr[ADDR_W+1:2];
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  wr_cnt_r;
    logic [CNT_W-1:0]  wr_cnt_nxt_s;
    logic              rd_ok_s;
    logic              rd_gnt_s;
    logic              wr_gnt_s;
    logic              wr_oor_s;
    logic              rd_oor_s;
    logic              rd_kill_s;

    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              wr_valid_r;
    logic              rd_valid_r;
    logic [31:0]       rd_data_r;
    logic              addr_err_r;
    logic              rd_err_r;
    logic              rd_flush_r;
    logic              busy_r;

    assign rd_ok_s   = bus.i_rd_req & ~bus.i_flush;
    assign wr_oor_s  = addr_out_of_range(bus.i_wr_addr[31:2]);
    assign rd_oor_s  = addr_out_of_range(bus.i_rd_addr[31:2]);
    // A flush seen in either cycle of an outstanding read cancels its response
    assign rd_kill_s = rd_flush_r | bus.i_flush;

    // Arbitration, next-state and write-burst counter update
    always_comb begin
        state_nxt_s  = state_r;
        wr_cnt_nxt_s = wr_cnt_r;
        rd_gnt_s     = 1'b0;
        wr_gnt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (rd_ok_s && (wr_cnt_r == CNT_MAX)) begin
                    rd_gnt_s     = 1'b1;
                    state_nxt_s  = READ_ISSUE;
                    wr_cnt_nxt_s = CNT_ZERO;
                end else if (bus.i_wr_req) begin
                    wr_gnt_s     = 1'b1;
                    state_nxt_s  = WRITE;
                    wr_cnt_nxt_s = (wr_cnt_r == CNT_MAX) ? CNT_MAX : (wr_cnt_r + CNT_ONE);
                end else if (rd_ok_s) begin
                    rd_gnt_s     = 1'b1;
                    state_nxt_s  = READ_ISSUE;
                    wr_cnt_nxt_s = CNT_ZERO;
                end else begin
                    wr_cnt_nxt_s = CNT_ZERO;
                end
            end
            WRITE:      state_nxt_s = IDLE;
            READ_ISSUE: state_nxt_s = READ_RESP;
            READ_RESP:  state_nxt_s = IDLE;
            default:    state_nxt_s = IDLE;
        endcase
    end

    // State, burst counter and busy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= IDLE;
            wr_cnt_r <= CNT_ZERO;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wr_cnt_r <= wr_cnt_nxt_s;
            busy_r   <= (state_nxt_s != IDLE);
        end
    end

    // Memory command: one cycle per accepted in-range request, cleared otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'h0000_0000;
        end else if (wr_gnt_s && !wr_oor_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= word_addr(bus.i_wr_addr[31:2]);
            mem_wdata_r <= bus.i_wr_data;
        end else if (rd_gnt_s && !rd_oor_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= word_addr(bus.i_rd_addr[31:2]);
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'h0000_0000;
        end
    end

    // Per-read bookkeeping: range error and flush seen during READ_ISSUE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_err_r   <= 1'b0;
            rd_flush_r <= 1'b0;
        end else if (rd_gnt_s) begin
            rd_err_r   <= rd_oor_s;
            rd_flush_r <= 1'b0;
        end else if (state_r == READ_ISSUE) begin
            rd_err_r   <= rd_err_r;
            rd_flush_r <= bus.i_flush;
        end else begin
            rd_err_r   <= rd_err_r;
            rd_flush_r <= rd_flush_r;
        end
    end

    // Completion handshakes and read-data capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_valid_r <= 1'b0;
            rd_valid_r <= 1'b0;
            addr_err_r <= 1'b0;
            rd_data_r  <= 32'h0000_0000;
        end else begin
            wr_valid_r <= wr_gnt_s;
            rd_valid_r <= (state_r == READ_RESP) && !rd_kill_s;
            addr_err_r <= (wr_gnt_s && wr_oor_s) ||
                          ((state_r == READ_RESP) && rd_err_r && !rd_kill_s);
            // Out-of-range reads never touched the SRAM, so keep the old data
            if ((state_r == READ_RESP) && !rd_err_r) begin
                rd_data_r <= bus.i_mem_rdata;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign bus.o_rd_gnt    = rd_gnt_s;
    assign bus.o_wr_valid  = wr_valid_r;
    assign bus.o_rd_valid  = rd_valid_r;
    assign bus.o_rd_data   = rd_data_r;
    assign bus.o_addr_err  = addr_err_r;
    assign bus.o_mem_en    = mem_en_r;
    assign bus.o_mem_we    = mem_we_r;
    assign bus.o_mem_addr  = mem_addr_r;
    assign bus.o_mem_wdata = mem_wdata_r;
    assign bus.o_busy      = busy_r;

endmodule
